ifetch_stage: RTL and testbench

Instruction fetch stage at the front of the rvga pipeline. Holds the program counter and issues one single-outstanding request at a time to instruction memory over a valid/ready request channel and a valid-only response channel. Registers the fetched word and its PC into the decode stage. Supports redirects from the back end and stalls, and injects a canonical NOP (32'h0000_0013) whenever no valid instruction is presented.

---
 rtl/ifetch_stage_pkg.sv | 16 +
 rtl/ifetch_stage.sv | 160 ++++++++++++++++
 tb/tb_ifetch_stage.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/ifetch_stage_pkg.sv
// Shared types and constants for the rvga instruction fetch stage.
package ifetch_stage_pkg;

    typedef logic [31:0] rvga_word;

    typedef enum logic [1:0] {
        e_rvga_ifetch_idle = 2'd0,
        e_rvga_ifetch_req  = 2'd1,
        e_rvga_ifetch_wait = 2'd2,
        e_rvga_ifetch_hold = 2'd3
    } rvga_ifetch_state_e;

    localparam rvga_word RVGA_NOP        = 32'h0000_0013;
    localparam rvga_word RVGA_INST_BYTES = 32'd4;

endpackage

// File: rtl/ifetch_stage.sv
// rvga fetch stage: single-outstanding imem requests, redirect/stall handling,
// registered {pc, instruction, valid} into decode with NOP injection.
//
// state | meaning
// IDLE  | just out of reset, request next cycle
// REQ   | request valid on imem, waiting for ready
// WAIT  | request accepted, waiting for response
// HOLD  | response parked in skid while decode stalls
module ifetch_stage
    import ifetch_stage_pkg::*;
#(
    parameter rvga_word RESET_PC = 32'h0000_0000
) (
    input  logic     clk,
    input  logic     rst,
    output logic     imem_req_v,
    output rvga_word imem_req_addr,
    input  logic     imem_req_ready,
    input  logic     imem_resp_v,
    input  rvga_word imem_resp_data,
    input  logic     redirect_v,
    input  rvga_word redirect_pc,
    input  logic     stall,
    output rvga_word ifetch_decode_pc,
    output rvga_word ifetch_decode_instruction,
    output logic     ifetch_decode_v
);

    rvga_ifetch_state_e state_q, state_d;
    rvga_word           pc_q, pc_d;
    logic               kill_q, kill_d;
    rvga_word           skid_q, skid_d;
    rvga_word           skid_pc_q, skid_pc_d;
    rvga_word           dec_pc_q, dec_pc_d;
    rvga_word           dec_instr_q, dec_instr_d;
    logic               dec_v_q, dec_v_d;
    rvga_word           redirect_pc_aligned;

    assign redirect_pc_aligned = redirect_pc & ~32'h0000_0003;

    assign imem_req_v                = (state_q == e_rvga_ifetch_req);
    assign imem_req_addr             = pc_q;
    assign ifetch_decode_pc          = dec_pc_q;
    assign ifetch_decode_instruction = dec_instr_q;
    assign ifetch_decode_v           = dec_v_q;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        kill_d      = kill_q;
        skid_d      = skid_q;
        skid_pc_d   = skid_pc_q;
        dec_pc_d    = dec_pc_q;
        dec_instr_d = dec_instr_q;
        dec_v_d     = dec_v_q;

        // Nothing presented this cycle: bubble unless decode is holding.
        if (!stall) begin
            dec_instr_d = RVGA_NOP;
            dec_v_d     = 1'b0;
        end

        case (state_q)
            e_rvga_ifetch_idle: begin
                state_d = e_rvga_ifetch_req;
            end

            e_rvga_ifetch_req: begin
                if (redirect_v) begin
                    pc_d        = redirect_pc_aligned;
                    dec_instr_d = RVGA_NOP;
                    dec_v_d     = 1'b0;
                    if (imem_req_ready) begin
                        kill_d  = 1'b1;
                        state_d = e_rvga_ifetch_wait;
                    end
                end else if (imem_req_ready) begin
                    state_d = e_rvga_ifetch_wait;
                end
            end

            e_rvga_ifetch_wait: begin
                if (redirect_v) begin
                    pc_d        = redirect_pc_aligned;
                    dec_instr_d = RVGA_NOP;
                    dec_v_d     = 1'b0;
                    if (imem_resp_v) begin
                        kill_d  = 1'b0;
                        state_d = e_rvga_ifetch_req;
                    end else begin
                        kill_d  = 1'b1;
                    end
                end else if (imem_resp_v) begin
                    if (kill_q) begin
                        kill_d  = 1'b0;
                        state_d = e_rvga_ifetch_req;
                    end else if (!stall) begin
                        dec_pc_d    = pc_q;
                        dec_instr_d = imem_resp_data;
                        dec_v_d     = 1'b1;
                        pc_d        = pc_q + RVGA_INST_BYTES;
                        state_d     = e_rvga_ifetch_req;
                    end else begin
                        skid_d    = imem_resp_data;
                        skid_pc_d = pc_q;
                        pc_d      = pc_q + RVGA_INST_BYTES;
                        state_d   = e_rvga_ifetch_hold;
                    end
                end
            end

            e_rvga_ifetch_hold: begin
                if (redirect_v) begin
                    pc_d        = redirect_pc_aligned;
                    dec_instr_d = RVGA_NOP;
                    dec_v_d     = 1'b0;
                    state_d     = e_rvga_ifetch_req;
                end else if (!stall) begin
                    dec_pc_d    = skid_pc_q;
                    dec_instr_d = skid_q;
                    dec_v_d     = 1'b1;
                    state_d     = e_rvga_ifetch_req;
                end
            end

            default: begin
                state_d = e_rvga_ifetch_idle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= e_rvga_ifetch_idle;
            pc_q      <= RESET_PC;
            kill_q    <= 1'b0;
            skid_q    <= RVGA_NOP;
            skid_pc_q <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            kill_q    <= kill_d;
            skid_q    <= skid_d;
            skid_pc_q <= skid_pc_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dec_pc_q    <= '0;
            dec_instr_q <= RVGA_NOP;
            dec_v_q     <= 1'b0;
        end else begin
            dec_pc_q    <= dec_pc_d;
            dec_instr_q <= dec_instr_d;
            dec_v_q     <= dec_v_d;
        end
    end

endmodule

// File: tb/tb_ifetch_stage.sv
// Directed bench for ifetch_stage: per-cycle vector table plus a wrap/async-reset
// sequence on a second instance built with RESET_PC = 32'hFFFF_FFFC.
module tb_ifetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        req_v, ready, resp_v, redir_v, stall_s, dec_v;
    logic [31:0] req_addr, resp_data, redir_pc, dec_pc, dec_instr;

    logic        rst2;
    logic        req_v2, ready2, resp_v2, redir_v2, stall2, dec_v2;
    logic [31:0] req_addr2, resp_data2, redir_pc2, dec_pc2, dec_instr2;

    int tests = 0;
    int fails = 0;

    ifetch_stage #(.RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst(rst),
        .imem_req_v(req_v), .imem_req_addr(req_addr), .imem_req_ready(ready),
        .imem_resp_v(resp_v), .imem_resp_data(resp_data),
        .redirect_v(redir_v), .redirect_pc(redir_pc), .stall(stall_s),
        .ifetch_decode_pc(dec_pc), .ifetch_decode_instruction(dec_instr),
        .ifetch_decode_v(dec_v)
    );

    ifetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut2 (
        .clk(clk), .rst(rst2),
        .imem_req_v(req_v2), .imem_req_addr(req_addr2), .imem_req_ready(ready2),
        .imem_resp_v(resp_v2), .imem_resp_data(resp_data2),
        .redirect_v(redir_v2), .redirect_pc(redir_pc2), .stall(stall2),
        .ifetch_decode_pc(dec_pc2), .ifetch_decode_instruction(dec_instr2),
        .ifetch_decode_v(dec_v2)
    );

    typedef struct {
        logic        ready;
        logic        resp_v;
        logic [31:0] data;
        logic        redir;
        logic [31:0] rpc;
        logic        stall;
        logic        e_req_v;
        logic [31:0] e_addr;
        logic [31:0] e_pc;
        logic [31:0] e_instr;
        logic        e_v;
    } vec_t;

    localparam int NV = 23;
    vec_t vt [NV];

    task automatic chk(input string name, input int row, input logic [31:0] got,
                       input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s row %0d: got %h expected %h", name, row, got, exp);
        end
    endtask

    initial begin
        // ready resp  data          redir rpc           stall | req_v addr          pc            instr         v
        vt[0]  = '{0, 0, 32'h0,          0, 32'h0,     0,  0, 32'h0000_0000, 32'h0,     NOP,           0};
        vt[1]  = '{1, 0, 32'h0,          0, 32'h0,     0,  1, 32'h0000_0000, 32'h0,     NOP,           0};
        vt[2]  = '{0, 1, 32'h0050_0093,  0, 32'h0,     0,  0, 32'h0000_0000, 32'h0,     NOP,           0};
        vt[3]  = '{0, 0, 32'h0,          0, 32'h0,     0,  1, 32'h0000_0004, 32'h0,     32'h0050_0093, 1};
        vt[4]  = '{0, 0, 32'h0,          0, 32'h0,     0,  1, 32'h0000_0004, 32'h0,     NOP,           0};
        vt[5]  = '{0, 0, 32'h0,          0, 32'h0,     0,  1, 32'h0000_0004, 32'h0,     NOP,           0};
        vt[6]  = '{1, 0, 32'h0,          0, 32'h0,     0,  1, 32'h0000_0004, 32'h0,     NOP,           0};
        vt[7]  = '{0, 1, 32'h1234_5037,  0, 32'h0,     1,  0, 32'h0000_0004, 32'h0,     NOP,           0};
        vt[8]  = '{0, 0, 32'h0,          0, 32'h0,     1,  0, 32'h0000_0008, 32'h0,     NOP,           0};
        vt[9]  = '{0, 0, 32'h0,          0, 32'h0,     0,  0, 32'h0000_0008, 32'h0,     NOP,           0};
        vt[10] = '{1, 0, 32'h0,          0, 32'h0,     0,  1, 32'h0000_0008, 32'h4,     32'h1234_5037, 1};
        vt[11] = '{0, 0, 32'h0,          1, 32'h103,   0,  0, 32'h0000_0008, 32'h4,     NOP,           0};
        vt[12] = '{0, 0, 32'h0,          0, 32'h0,     0,  0, 32'h0000_0100, 32'h4,     NOP,           0};
        vt[13] = '{0, 1, 32'hDEAD_BEEF,  0, 32'h0,     0,  0, 32'h0000_0100, 32'h4,     NOP,           0};
        vt[14] = '{1, 0, 32'h0,          1, 32'h200,   0,  1, 32'h0000_0100, 32'h4,     NOP,           0};
        vt[15] = '{0, 1, 32'hBAD0_0001,  1, 32'h302,   0,  0, 32'h0000_0200, 32'h4,     NOP,           0};
        vt[16] = '{1, 0, 32'h0,          0, 32'h0,     0,  1, 32'h0000_0300, 32'h4,     NOP,           0};
        vt[17] = '{0, 1, 32'h0000_0113,  0, 32'h0,     0,  0, 32'h0000_0300, 32'h4,     NOP,           0};
        vt[18] = '{1, 0, 32'h0,          0, 32'h0,     1,  1, 32'h0000_0304, 32'h300,   32'h0000_0113, 1};
        vt[19] = '{0, 1, 32'h0000_0055,  0, 32'h0,     1,  0, 32'h0000_0304, 32'h300,   32'h0000_0113, 1};
        vt[20] = '{0, 0, 32'h0,          1, 32'h400,   1,  0, 32'h0000_0308, 32'h300,   32'h0000_0113, 1};
        vt[21] = '{0, 0, 32'h0,          1, 32'h501,   0,  1, 32'h0000_0400, 32'h300,   NOP,           0};
        vt[22] = '{0, 0, 32'h0,          0, 32'h0,     0,  1, 32'h0000_0500, 32'h300,   NOP,           0};

        rst = 1'b1; ready = 0; resp_v = 0; resp_data = 0; redir_v = 0; redir_pc = 0; stall_s = 0;
        rst2 = 1'b1; ready2 = 0; resp_v2 = 0; resp_data2 = 0; redir_v2 = 0; redir_pc2 = 0; stall2 = 0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_req_v", -1, {31'b0, req_v}, 32'd0);
        chk("rst_addr",  -1, req_addr, 32'h0);
        chk("rst_instr", -1, dec_instr, NOP);
        chk("rst_dec_v", -1, {31'b0, dec_v}, 32'd0);
        rst = 1'b0;

        for (int i = 0; i < NV; i++) begin
            ready     = vt[i].ready;
            resp_v    = vt[i].resp_v;
            resp_data = vt[i].data;
            redir_v   = vt[i].redir;
            redir_pc  = vt[i].rpc;
            stall_s   = vt[i].stall;
            #1;
            chk("req_v", i, {31'b0, req_v}, {31'b0, vt[i].e_req_v});
            chk("req_addr", i, req_addr, vt[i].e_addr);
            chk("dec_pc", i, dec_pc, vt[i].e_pc);
            chk("dec_instr", i, dec_instr, vt[i].e_instr);
            chk("dec_v", i, {31'b0, dec_v}, {31'b0, vt[i].e_v});
            @(negedge clk);
        end

        // Wrap of pc from 0xFFFF_FFFC and async reset while in WAIT.
        rst2 = 1'b0;
        #1;
        chk("w_idle_req_v", 0, {31'b0, req_v2}, 32'd0);
        @(negedge clk);
        ready2 = 1'b1;
        #1;
        chk("w_first_addr", 1, req_addr2, 32'hFFFF_FFFC);
        chk("w_first_req_v", 1, {31'b0, req_v2}, 32'd1);
        @(negedge clk);
        ready2 = 1'b0; resp_v2 = 1'b1; resp_data2 = 32'h00A0_0093;
        @(negedge clk);
        resp_v2 = 1'b0; ready2 = 1'b1; stall2 = 1'b1;
        #1;
        chk("w_second_addr", 3, req_addr2, 32'h0000_0000);
        chk("w_dec_pc", 3, dec_pc2, 32'hFFFF_FFFC);
        chk("w_dec_instr", 3, dec_instr2, 32'h00A0_0093);
        chk("w_dec_v", 3, {31'b0, dec_v2}, 32'd1);
        @(negedge clk);
        ready2 = 1'b0;
        #1;
        chk("w_wait_req_v", 4, {31'b0, req_v2}, 32'd0);
        chk("w_held_v", 4, {31'b0, dec_v2}, 32'd1);
        #1;
        rst2 = 1'b1;
        #1;
        chk("ar_instr", 4, dec_instr2, NOP);
        chk("ar_dec_v", 4, {31'b0, dec_v2}, 32'd0);
        chk("ar_dec_pc", 4, dec_pc2, 32'h0);
        chk("ar_addr", 4, req_addr2, 32'hFFFF_FFFC);
        @(negedge clk);
        rst2 = 1'b0; stall2 = 1'b0; resp_v2 = 1'b1; resp_data2 = 32'h0000_0777;
        #1;
        chk("ar_idle_req_v", 5, {31'b0, req_v2}, 32'd0);
        @(negedge clk);
        resp_v2 = 1'b1;
        #1;
        chk("ar_req_v", 6, {31'b0, req_v2}, 32'd1);
        chk("ar_ignore_v", 6, {31'b0, dec_v2}, 32'd0);
        @(negedge clk);
        resp_v2 = 1'b0;
        #1;
        chk("ar_still_req", 7, {31'b0, req_v2}, 32'd1);
        chk("ar_ignore_v2", 7, {31'b0, dec_v2}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
